bscan_chain: RTL and testbench

- Parametrised boundary-scan chain of NUM_CELLS probe cells. Each cell is 3 bits: input, tristate, output.
- JTAG-style CAPTURE/SHIFT/UPDATE staging: drive settings are held in an update register, so shifting never disturbs the probed pins.
- Adds two things the current fixed-width chain lacks: synchronised input sampling, and a parameter-configured contention interlock between cells.
- Sits between the debug TAP controller and the processor's memory, storage, GPIO and status pins.

---
 rtl/bscan_pkg.sv | 14 +
 rtl/bscan_cell.sv | 53 +++++
 rtl/bscan_chain.sv | 81 ++++++++
 tb/tb_bscan_chain.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bscan_pkg.sv
// Shared constants for the boundary-scan chain: cell bit layout and index width helper.
package bscan_pkg;

  localparam int CELL_W   = 3;
  localparam int CELL_IN  = 0;
  localparam int CELL_TRI = 1;
  localparam int CELL_OUT = 2;

  // Width needed to index n cells; never zero so a single-cell chain still elaborates.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bscan_cell.sv
// One boundary-scan probe cell: 3 shift bits, 2 update bits, input synchroniser, tristate pad.
module bscan_cell
  import bscan_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic chainIn,
  input  logic doShift,
  input  logic doCapture,
  input  logic doUpdate,
  input  logic en,
  inout  wire  probe,
  output logic chainOut,
  output logic urTri
);

  logic [CELL_W-1:0]      srReg;
  logic                   urTriReg;
  logic                   urOutReg;
  logic [SYNC_STAGES-1:0] syncReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      srReg    <= '0;
      urTriReg <= 1'b0;
      urOutReg <= 1'b0;
      syncReg  <= '0;
    end else begin
      // The synchroniser free-runs so readback is always SYNC_STAGES cycles behind the pin.
      syncReg[0] <= probe;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncReg[s] <= syncReg[s-1];
      end
      if (doShift) begin
        srReg <= {srReg[CELL_W-2:0], chainIn};
      end else if (doCapture) begin
        srReg[CELL_IN]  <= syncReg[SYNC_STAGES-1];
        srReg[CELL_TRI] <= urTriReg;
        srReg[CELL_OUT] <= urOutReg;
      end else if (doUpdate) begin
        urTriReg <= srReg[CELL_TRI];
        urOutReg <= srReg[CELL_OUT];
      end
    end
  end

  assign probe    = en ? urOutReg : 1'bz;
  assign chainOut = srReg[CELL_OUT];
  assign urTri    = urTriReg;

endmodule

// File: rtl/bscan_chain.sv
// Boundary-scan chain of NUM_CELLS probe cells with staged update and a per-cell drive interlock.
module bscan_chain
  import bscan_pkg::*;
#(
  parameter int                                      NUM_CELLS   = 56,
  parameter int                                      SYNC_STAGES = 2,
  parameter logic [NUM_CELLS-1:0]                    GUARD_EN    = '0,
  parameter logic [NUM_CELLS*idx_w(NUM_CELLS)-1:0]   GUARD_SRC   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_shiftIn,
  output logic                 o_shiftOut,
  inout  wire  [NUM_CELLS-1:0] io_probe,
  input  logic                 i_canDrive,
  input  logic                 i_capture,
  input  logic                 i_doShift,
  input  logic                 i_update,
  output logic [NUM_CELLS-1:0] o_driving
);

  localparam int IDX_W = idx_w(NUM_CELLS);

  logic                 doShift;
  logic                 doCapture;
  logic                 doUpdate;
  logic [NUM_CELLS-1:0] urTri;
  logic [NUM_CELLS-1:0] req;
  logic [NUM_CELLS-1:0] guard;
  logic [NUM_CELLS-1:0] en;
  logic [NUM_CELLS:0]   link;

  if (SYNC_STAGES < 1) begin : g_syncCheck
    $error("bscan_chain: SYNC_STAGES must be at least 1");
  end

  // One command per cycle; lower-priority requests are dropped, not queued.
  assign doShift   = i_doShift;
  assign doCapture = ~i_doShift & i_capture;
  assign doUpdate  = ~i_doShift & ~i_capture & i_update;

  assign req       = {NUM_CELLS{i_canDrive}} & urTri;
  assign en        = req & ~guard;
  assign o_driving = en;
  assign link[0]   = i_shiftIn;
  assign o_shiftOut = link[NUM_CELLS];

  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    // A guard source may not itself be guarded, which keeps the interlock loop-free.
    if (GUARD_EN[gi]) begin : g_guard
      localparam int SRC = int'(GUARD_SRC[gi*IDX_W +: IDX_W]);
      if (SRC >= NUM_CELLS) begin : g_badRange
        $error("bscan_chain: GUARD_SRC field %0d out of range", gi);
        assign guard[gi] = 1'b0;
      end else if (SRC == gi || GUARD_EN[SRC]) begin : g_badSrc
        $error("bscan_chain: cell %0d guarded by itself or by a guarded cell", gi);
        assign guard[gi] = 1'b0;
      end else begin : g_ok
        assign guard[gi] = req[SRC];
      end
    end else begin : g_noGuard
      assign guard[gi] = 1'b0;
    end

    bscan_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk      (i_clk),
      .rst      (i_rst),
      .chainIn  (link[gi]),
      .doShift  (doShift),
      .doCapture(doCapture),
      .doUpdate (doUpdate),
      .en       (en[gi]),
      .probe    (io_probe[gi]),
      .chainOut (link[gi+1]),
      .urTri    (urTri[gi])
    );
  end

endmodule

// File: tb/tb_bscan_chain.sv
// Self-checking bench for bscan_chain: 4 cells, cell1 interlocked against cell3, randomised data.
module tb_bscan_chain;

  localparam int N = 4;
  localparam int L = 3 * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shiftIn = 1'b0;
  logic       canDrive = 1'b0;
  logic       capture = 1'b0;
  logic       doShift = 1'b0;
  logic       update = 1'b0;
  wire        shiftOut;
  wire  [N-1:0] driving;
  wire  [N-1:0] probe;
  logic [N-1:0] tbEn = '0;
  logic [N-1:0] tbVal = '0;

  int checks = 0;
  int failures = 0;

  // Reference state: scan register as a plain bit vector, update register as two per-cell vectors.
  logic [L-1:0] mSr;
  logic [N-1:0] mTri;
  logic [N-1:0] mOut;

  always #5 clk = ~clk;

  // Undriven pins float high so a released line is distinguishable from one driven low.
  for (genvar gi = 0; gi < N; gi++) begin : g_pin
    assign probe[gi] = tbEn[gi] ? tbVal[gi] : 1'bz;
    pullup pu (probe[gi]);
  end

  bscan_chain #(
    .NUM_CELLS  (N),
    .SYNC_STAGES(2),
    .GUARD_EN   (4'b0010),
    .GUARD_SRC  (8'b0000_1100)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_shiftIn (shiftIn),
    .o_shiftOut(shiftOut),
    .io_probe  (probe),
    .i_canDrive(canDrive),
    .i_capture (capture),
    .i_doShift (doShift),
    .i_update  (update),
    .o_driving (driving)
  );

  // Cell 1 may drive only while cell 3 is not requesting.
  function automatic logic [N-1:0] expEn(input logic cd);
    logic [N-1:0] r;
    r = cd ? mTri : '0;
    if (r[3]) r[1] = 1'b0;
    return r;
  endfunction

  function automatic logic [N-1:0] expPins(input logic cd);
    logic [N-1:0] e;
    logic [N-1:0] p;
    e = expEn(cd);
    for (int k = 0; k < N; k++)
      p[k] = tbEn[k] ? tbVal[k] : (e[k] ? mOut[k] : 1'b1);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shiftBit(input logic b, output logic o);
    o = shiftOut;
    shiftIn = b;
    doShift = 1'b1;
    tick();
    doShift = 1'b0;
    mSr = {mSr[L-2:0], b};
  endtask

  // Shift a whole word MSB-first; afterwards SR holds w and outw holds the previous SR.
  task automatic shiftWord(input logic [L-1:0] w, output logic [L-1:0] outw);
    logic o;
    for (int i = L - 1; i >= 0; i--) begin
      shiftBit(w[i], o);
      outw[i] = o;
    end
  endtask

  task automatic pulseUpdate();
    update = 1'b1;
    tick();
    update = 1'b0;
    for (int k = 0; k < N; k++) begin
      mTri[k] = mSr[3*k+1];
      mOut[k] = mSr[3*k+2];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; canDrive = 1'b1; doShift = 1'b1; shiftIn = 1'b1;
    tick();
    tick();
    mSr = '0; mTri = '0; mOut = '0;
    rst = 1'b0; doShift = 1'b0; shiftIn = 1'b0;
    checks++; if (shiftOut !== 1'b0) begin failures++; $display("FAIL reset_shiftOut got=%b want=0", shiftOut); end
    checks++; if (driving !== 4'b0000) begin failures++; $display("FAIL reset_driving got=%b want=0000", driving); end
    checks++; if (probe !== 4'b1111) begin failures++; $display("FAIL reset_probe got=%b want=1111 (released)", probe); end
    $display("reset: shiftOut=%b driving=%b probe=%b", shiftOut, driving, probe);
  endtask

  task automatic test_load_drive();
    logic [L-1:0] w, outw, prev;
    w = 12'b000_010_000_110;
    for (int k = 0; k < N; k++) w[3*k] = 1'($urandom);
    prev = mSr;
    shiftWord(w, outw);
    checks++; if (outw !== prev) begin failures++; $display("FAIL load_shiftout got=%h want=%h", outw, prev); end
    canDrive = 1'b1;
    pulseUpdate();
    checks++; if (driving !== expEn(1'b1)) begin failures++; $display("FAIL load_driving got=%b want=%b", driving, expEn(1'b1)); end
    checks++; if (probe !== expPins(1'b1)) begin failures++; $display("FAIL load_probe got=%b want=%b", probe, expPins(1'b1)); end
    checks++; if (shiftOut !== mSr[L-1]) begin failures++; $display("FAIL load_sr_kept got=%b want=%b", shiftOut, mSr[L-1]); end
    $display("load_drive: word=%h driving=%b probe=%b", w, driving, probe);
  endtask

  task automatic test_capture();
    logic [L-1:0] outw, expw;
    logic [N-1:0] pins;
    tbEn = 4'b1010; tbVal = 4'b1000;
    tick();
    tick();
    pins = expPins(canDrive);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int k = 0; k < N; k++) begin
      mSr[3*k]   = pins[k];
      mSr[3*k+1] = mTri[k];
      mSr[3*k+2] = mOut[k];
    end
    expw = mSr;
    shiftWord(L'($urandom), outw);
    checks++; if (outw !== expw) begin failures++; $display("FAIL capture_readback got=%b want=%b", outw, expw); end
    tbEn = '0;
    $display("capture: readback=%b", outw);
  endtask

  task automatic test_guard();
    logic [L-1:0] w, outw;
    w = L'($urandom);
    w[5:4] = 2'b01;
    w[11:10] = 2'b11;
    shiftWord(w, outw);
    pulseUpdate();
    checks++; if (driving !== expEn(1'b1)) begin failures++; $display("FAIL guard_on_driving got=%b want=%b", driving, expEn(1'b1)); end
    checks++; if (probe !== expPins(1'b1)) begin failures++; $display("FAIL guard_on_probe got=%b want=%b", probe, expPins(1'b1)); end
    w[10] = 1'b0;
    shiftWord(w, outw);
    pulseUpdate();
    checks++; if (driving !== expEn(1'b1)) begin failures++; $display("FAIL guard_off_driving got=%b want=%b", driving, expEn(1'b1)); end
    checks++; if (probe[1] !== 1'b0) begin failures++; $display("FAIL guard_release_pin1 got=%b want=0", probe[1]); end
    $display("guard: driving=%b probe=%b", driving, probe);
  endtask

  task automatic test_perm_drop();
    canDrive = 1'b0;
    #1;
    checks++; if (driving !== 4'b0000) begin failures++; $display("FAIL drop_driving got=%b want=0000", driving); end
    checks++; if (probe !== 4'b1111) begin failures++; $display("FAIL drop_probe got=%b want=1111", probe); end
    tick();
    tick();
    canDrive = 1'b1;
    #1;
    checks++; if (driving !== expEn(1'b1)) begin failures++; $display("FAIL restore_driving got=%b want=%b", driving, expEn(1'b1)); end
    checks++; if (probe !== expPins(1'b1)) begin failures++; $display("FAIL restore_probe got=%b want=%b", probe, expPins(1'b1)); end
    $display("perm_drop: restored driving=%b probe=%b", driving, probe);
  endtask

  task automatic test_collision();
    logic o, b;
    for (int i = 0; i < 3; i++) shiftBit(1'($urandom), o);
    b = 1'($urandom);
    shiftIn = b; doShift = 1'b1; update = 1'b1;
    tick();
    doShift = 1'b0; update = 1'b0;
    mSr = {mSr[L-2:0], b};
    checks++; if (driving !== expEn(canDrive)) begin failures++; $display("FAIL collision_ur got=%b want=%b", driving, expEn(canDrive)); end
    checks++; if (shiftOut !== mSr[L-1]) begin failures++; $display("FAIL collision_shift got=%b want=%b", shiftOut, mSr[L-1]); end
    $display("collision: driving=%b shiftOut=%b", driving, shiftOut);
  endtask

  task automatic test_random();
    logic [L-1:0] w, outw, prev, expw;
    logic [N-1:0] pins;
    int cmd;
    for (int r = 0; r < 8; r++) begin
      canDrive = 1'($urandom);
      w = L'($urandom);
      prev = mSr;
      shiftWord(w, outw);
      checks++; if (outw !== prev) begin failures++; $display("FAIL rand%0d_shiftout got=%h want=%h", r, outw, prev); end
      cmd = $urandom_range(0, 2);
      if (cmd == 0) begin
        pulseUpdate();
      end else if (cmd == 1) begin
        pins = expPins(canDrive);
        capture = 1'b1; update = 1'b1;
        tick();
        capture = 1'b0; update = 1'b0;
        for (int k = 0; k < N; k++) begin
          mSr[3*k]   = pins[k];
          mSr[3*k+1] = mTri[k];
          mSr[3*k+2] = mOut[k];
        end
      end else begin
        tick();
      end
      expw = mSr;
      checks++; if (driving !== expEn(canDrive)) begin failures++; $display("FAIL rand%0d_driving got=%b want=%b", r, driving, expEn(canDrive)); end
      checks++; if (probe !== expPins(canDrive)) begin failures++; $display("FAIL rand%0d_probe got=%b want=%b", r, probe, expPins(canDrive)); end
      checks++; if (shiftOut !== expw[L-1]) begin failures++; $display("FAIL rand%0d_msb got=%b want=%b", r, shiftOut, expw[L-1]); end
      $display("random %0d: cmd=%0d canDrive=%b word=%h driving=%b probe=%b", r, cmd, canDrive, w, driving, probe);
    end
  endtask

  task automatic test_abort();
    logic o;
    logic [L-1:0] outw;
    canDrive = 1'b1;
    for (int i = 0; i < 5; i++) shiftBit(1'($urandom), o);
    rst = 1'b1; doShift = 1'b1; shiftIn = 1'b1;
    tick();
    rst = 1'b0; doShift = 1'b0; shiftIn = 1'b0;
    mSr = '0; mTri = '0; mOut = '0;
    checks++; if (shiftOut !== 1'b0) begin failures++; $display("FAIL abort_shiftOut got=%b want=0", shiftOut); end
    checks++; if (driving !== 4'b0000) begin failures++; $display("FAIL abort_driving got=%b want=0000", driving); end
    checks++; if (probe !== 4'b1111) begin failures++; $display("FAIL abort_probe got=%b want=1111", probe); end
    shiftWord(L'($urandom), outw);
    checks++; if (outw !== '0) begin failures++; $display("FAIL abort_sr got=%h want=000", outw); end
    $display("abort: sr=%h driving=%b probe=%b", outw, driving, probe);
  endtask

  initial begin
    mSr = '0; mTri = '0; mOut = '0;
    test_reset();
    test_load_drive();
    test_capture();
    test_guard();
    test_perm_drop();
    test_collision();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
